// File: rtl/ps2_host_tx_if.sv
// Bus-side signal bundle for the PS/2 host transmitter: single-cycle strobe/ack
// slave with a 32-bit write data path and a 32-bit status read-back.
interface ps2_host_tx_if;
    logic        stb;
    logic        we;
    logic [31:0] dat_i;
    logic        ack;
    logic [31:0] dat_o;

    modport master (output stb, output we, output dat_i, input ack, input dat_o);
    modport slave  (input stb, input we, input dat_i, output ack, output dat_o);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the link, clocks out one
// command byte under device clocking, and checks the device ACK bit.

// Two-flop synchronizer followed by a level filter; a new level is accepted
// only after FILTER_LEN consecutive samples disagree with the current one.
module ps2_host_tx_filt #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level
);
    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic          r_meta;
    logic          r_sync;
    logic [CW-1:0] r_cnt;

    // Reset to the idle-high line level so release from reset never looks like a fall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_cnt   <= '0;
            o_level <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            if (r_sync != o_level) begin
                if (r_cnt == CW'(FILTER_LEN - 1)) begin
                    o_level <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule

// state     | meaning
// IDLE      | lines released, waiting for a command write
// INHIBIT   | PS2C held low for INHIBIT_CYCLES
// START     | PS2C and PS2D both low for one cycle (request-to-send)
// SHIFT     | PS2C released; data/parity/stop driven on device clock falls 1..10
// WAIT_ACK  | lines released; PS2D sampled on fall 11 as the device ACK
// WAIT_IDLE | waiting for both lines high before reporting done
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ps2_host_tx_if.slave  bus,
    input  logic          i_ps2c_in,
    input  logic          i_ps2d_in,
    output logic          o_ps2c_oe,
    output logic          o_ps2d_oe,
    output logic          o_busy,
    output logic          o_rx_inhibit
);
    localparam int TMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_WAIT_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tmr;
    logic [7:0]    r_tx_byte;
    logic          r_parity;
    logic [3:0]    r_bitcnt;
    logic          r_d_oe;
    logic          r_done;
    logic          r_err_to;
    logic          r_err_nack;
    logic          r_ovr;
    logic          r_c_filt_d;

    logic          w_c_filt;
    logic          w_d_filt;
    logic          w_fall;
    logic          w_wr;
    logic          w_rd;
    logic          w_accept;
    logic          w_tmr_zero;
    logic          w_timing;
    logic          w_timeout;
    logic          w_set_done;
    logic          w_set_nack;
    logic          w_set_ovr;
    logic          w_busy;
    logic [9:0]    w_frame;
    logic          w_unused_ok;

    ps2_host_tx_filt #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_ps2c_in),
        .o_level (w_c_filt)
    );

    ps2_host_tx_filt #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_ps2d_in),
        .o_level (w_d_filt)
    );

    assign w_fall      = r_c_filt_d & ~w_c_filt;
    assign w_wr        = bus.stb & bus.we;
    assign w_rd        = bus.stb & ~bus.we;
    assign w_accept    = w_wr & (r_state == S_IDLE);
    assign w_tmr_zero  = (r_tmr == '0);
    assign w_timing    = (r_state == S_SHIFT) | (r_state == S_WAIT_ACK) | (r_state == S_WAIT_IDLE);
    assign w_timeout   = w_timing & w_tmr_zero;
    assign w_set_done  = w_timeout | ((r_state == S_WAIT_IDLE) & w_c_filt & w_d_filt);
    assign w_set_nack  = (r_state == S_WAIT_ACK) & ~w_tmr_zero & w_fall & w_d_filt;
    assign w_set_ovr   = w_wr & (r_state != S_IDLE);
    // Bit n (1..10) of the frame lives at index n-1: data LSB first, parity, stop.
    assign w_frame     = {1'b1, r_parity, r_tx_byte};
    assign w_unused_ok = ^bus.dat_i[31:8];

    assign bus.ack      = bus.stb;
    assign bus.dat_o    = {19'b0, r_ovr, r_err_nack, r_err_to, r_done, w_busy, r_tx_byte};
    assign o_busy       = w_busy;
    assign o_rx_inhibit = w_busy;

    always_comb begin
        w_next    = r_state;
        o_ps2c_oe = 1'b0;
        o_ps2d_oe = 1'b0;
        w_busy    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_accept) w_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                o_ps2c_oe = 1'b1;
                if (w_tmr_zero) w_next = S_START;
            end
            S_START: begin
                o_ps2c_oe = 1'b1;
                o_ps2d_oe = 1'b1;
                w_next    = S_SHIFT;
            end
            S_SHIFT: begin
                o_ps2d_oe = r_d_oe;
                if (w_tmr_zero)                     w_next = S_IDLE;
                else if (w_fall && r_bitcnt == 4'd9) w_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (w_tmr_zero)  w_next = S_IDLE;
                else if (w_fall) w_next = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (w_tmr_zero)                w_next = S_IDLE;
                else if (w_c_filt && w_d_filt) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
                w_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_c_filt_d <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_c_filt_d <= w_c_filt;
        end
    end

    // One down-counter serves both the inhibit hold and the frame timeout.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmr <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) r_tmr <= TW'(INHIBIT_CYCLES - 1);
                S_START: r_tmr <= TW'(TIMEOUT_CYCLES - 1);
                default: if (!w_tmr_zero) r_tmr <= r_tmr - TW'(1);
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_byte <= '0;
            r_parity  <= 1'b0;
            r_bitcnt  <= '0;
            r_d_oe    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tx_byte <= bus.dat_i[7:0];
                r_parity  <= ~^bus.dat_i[7:0];
            end
            case (r_state)
                S_START: begin
                    r_d_oe   <= 1'b1;
                    r_bitcnt <= '0;
                end
                S_SHIFT: begin
                    if (w_fall && !w_tmr_zero) begin
                        r_d_oe   <= ~w_frame[r_bitcnt];
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                end
                default: r_d_oe <= 1'b0;
            endcase
        end
    end

    // A set event in the same cycle as a status read takes priority over the clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done     <= 1'b0;
            r_err_to   <= 1'b0;
            r_err_nack <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_done     <= w_set_done | (r_done     & ~w_rd & ~w_accept);
            r_err_to   <= w_timeout  | (r_err_to   & ~w_rd & ~w_accept);
            r_err_nack <= w_set_nack | (r_err_nack & ~w_rd & ~w_accept);
            r_ovr      <= w_set_ovr  | (r_ovr      & ~w_rd);
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of
// the host and each scenario compares against hand-computed frames and status words.
module tb_ps2_host_tx;
    localparam int INH = 200;
    localparam int TO  = 3000;
    localparam int FL  = 8;
    localparam int H   = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    logic ps2c_oe, ps2d_oe, busy, rx_inh;
    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    logic ps2c_in, ps2d_in;
    assign ps2c_in = ~(ps2c_oe | dev_c_low);
    assign ps2d_in = ~(ps2d_oe | dev_d_low);

    int n_vec = 0;
    int n_err = 0;
    int dev_falls = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .i_ps2c_in    (ps2c_in),
        .i_ps2d_in    (ps2d_in),
        .o_ps2c_oe    (ps2c_oe),
        .o_ps2d_oe    (ps2d_oe),
        .o_busy       (busy),
        .o_rx_inhibit (rx_inh)
    );

    task automatic bus_write(input logic [31:0] d);
        @(negedge clk);
        bus.stb = 1'b1; bus.we = 1'b1; bus.dat_i = d;
        @(negedge clk);
        bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(output logic [31:0] d, output logic a);
        @(negedge clk);
        bus.stb = 1'b1; bus.we = 1'b0;
        #1;
        d = bus.dat_o;
        a = bus.ack;
        @(negedge clk);
        bus.stb = 1'b0;
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Device side: waits for the host to release PS2C, then generates 11 clocks,
    // sampling PS2D late in each high phase; optional 3-cycle glitch after fall glitch_at.
    task automatic device_frame(input bit ack_ok, input int glitch_at,
                                output logic [10:0] frame, output bit ok);
        int t;
        ok = 1'b1;
        frame = '0;
        dev_falls = 0;
        t = 0;
        while (!ps2c_oe && t < 1000) begin @(negedge clk); t++; end
        t = 0;
        while (ps2c_oe && t < INH + 1000) begin @(negedge clk); t++; end
        if (ps2c_oe || t == 0) ok = 1'b0;
        if (!ok) return;
        repeat (H) @(negedge clk);
        frame[0] = ps2d_in;
        for (int i = 1; i <= 10; i++) begin
            dev_c_low = 1'b1;
            dev_falls = i;
            repeat (H) @(negedge clk);
            dev_c_low = 1'b0;
            if (i == glitch_at) begin
                repeat (15) @(negedge clk);
                dev_c_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_c_low = 1'b0;
                repeat (H - 18) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            frame[i] = ps2d_in;
        end
        if (ack_ok) dev_d_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_c_low = 1'b1;
        dev_falls = 11;
        repeat (H) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (H) @(negedge clk);
        dev_d_low = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic run_frame(input string name, input logic [7:0] cmd, input bit ack_ok,
                             input int glitch_at, input logic [10:0] exp_frame,
                             input logic [31:0] exp_stat);
        logic [10:0] fr;
        bit          ok;
        logic [31:0] d;
        logic        a;
        bus_write({24'h0, cmd});
        device_frame(ack_ok, glitch_at, fr, ok);
        check32({name, "_dev_start"}, {31'b0, ok}, 32'd1);
        check32({name, "_frame"}, {21'b0, fr}, {21'b0, exp_frame});
        bus_read(d, a);
        check32({name, "_status"}, d, exp_stat);
        check32({name, "_lines"}, {29'b0, ps2c_oe, ps2d_oe, busy}, 32'd0);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        a;
        bus.stb = 1'b0; bus.we = 1'b0; bus.dat_i = '0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check32("reset_outputs", {27'b0, ps2c_oe, ps2d_oe, busy, rx_inh, bus.ack}, 32'd0);
        check32("reset_dat_o", bus.dat_o, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        bus_read(d, a);
        check32("reset_read", {d[30:0], a}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            dev_c_low = 1'b1; repeat (H) @(negedge clk);
            dev_c_low = 1'b0; repeat (H) @(negedge clk);
        end
        check32("idle_clocks_ignored", {30'b0, busy, ps2d_oe}, 32'd0);
        bus_read(d, a);
        check32("idle_clocks_status", d, 32'd0);
    endtask

    task automatic test_basic();
        logic [10:0] fr;
        bit          ok;
        int          cnt;
        logic [31:0] d;
        logic        a;
        bus_write(32'h0000_00ED);
        fork
            device_frame(1'b1, 0, fr, ok);
            begin
                cnt = 0;
                while (ps2c_oe && !ps2d_oe && cnt < INH + 100) begin
                    cnt++;
                    @(negedge clk);
                end
                check32("inhibit_len", cnt, INH);
                check32("start_bit_lines", {30'b0, ps2c_oe, ps2d_oe}, 32'd3);
                check32("busy_rx_inhibit", {30'b0, busy, rx_inh}, 32'd3);
                @(negedge clk);
                check32("shift_clock_released", {30'b0, ps2c_oe, ps2d_oe}, 32'd1);
            end
        join
        check32("basic_dev_start", {31'b0, ok}, 32'd1);
        check32("basic_frame", {21'b0, fr}, {21'b0, 1'b1, 1'b1, 8'hED, 1'b0});
        bus_read(d, a);
        check32("basic_status", d, 32'h0000_02ED);
        bus_read(d, a);
        check32("basic_status_cleared", d, 32'h0000_00ED);
    endtask

    task automatic test_nack();
        run_frame("nack", 8'hF4, 1'b0, 0, {1'b1, 1'b0, 8'hF4, 1'b0}, 32'h0000_0AF4);
    endtask

    task automatic test_timeout();
        int          t;
        int          cnt;
        logic [31:0] d;
        logic        a;
        bus_write(32'h0000_00FF);
        t = 0;
        while (ps2c_oe && t < INH + 100) begin @(negedge clk); t++; end
        check32("to_clock_released", {31'b0, ps2c_oe}, 32'd0);
        cnt = 0;
        while (busy && cnt < TO + 100) begin
            cnt++;
            @(negedge clk);
        end
        check32("timeout_len", cnt, TO);
        check32("timeout_lines", {30'b0, ps2c_oe, ps2d_oe}, 32'd0);
        bus_read(d, a);
        check32("timeout_status", d, 32'h0000_06FF);
    endtask

    task automatic test_overrun();
        logic [10:0] fr;
        bit          ok;
        int          t;
        logic [31:0] d;
        logic        a;
        bus_write(32'h0000_00ED);
        fork
            device_frame(1'b1, 0, fr, ok);
            begin
                t = 0;
                while (dev_falls < 3 && t < INH + 2000) begin @(negedge clk); t++; end
                bus_write(32'h0000_0055);
                bus_read(d, a);
                check32("ovr_set", d, 32'h0000_11ED);
                bus_read(d, a);
                check32("ovr_cleared", d, 32'h0000_01ED);
            end
        join
        check32("ovr_frame", {21'b0, fr}, {21'b0, 1'b1, 1'b1, 8'hED, 1'b0});
        bus_read(d, a);
        check32("ovr_final_status", d, 32'h0000_02ED);
    endtask

    task automatic test_reset_mid();
        logic [10:0] fr;
        bit          ok;
        int          t;
        logic [31:0] d;
        logic        a;
        bus_write(32'h0000_00ED);
        fork
            device_frame(1'b1, 0, fr, ok);
            begin
                t = 0;
                while (dev_falls < 5 && t < INH + 2000) begin @(negedge clk); t++; end
                repeat (H / 2) @(negedge clk);
                check32("pre_reset_lines", {30'b0, ps2d_oe, busy}, 32'd3);
                #2;
                rst = 1'b1;
                #1;
                check32("async_reset_lines", {29'b0, ps2c_oe, ps2d_oe, busy}, 32'd0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        check32("post_reset_idle", {29'b0, ps2c_oe, ps2d_oe, busy}, 32'd0);
        bus_read(d, a);
        check32("post_reset_dat_o", d, 32'd0);
        run_frame("after_reset", 8'h3C, 1'b1, 0, {1'b1, 1'b1, 8'h3C, 1'b0}, 32'h0000_023C);
    endtask

    task automatic test_glitch();
        run_frame("glitch", 8'hA5, 1'b1, 4, {1'b1, 1'b1, 8'hA5, 1'b0}, 32'h0000_02A5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_nack();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
